// File: rtl/care_scheduler.sv
// Arbitrates UART care commands (FIFO-buffered) and the periodic decay tick onto one valid/ready action channel.
// Optional: define CARE_DEDUP_EN to drop a command equal to the newest still-queued FIFO entry.
module care_scheduler #(
    parameter int TICK_CYCLES = 27000000,
    parameter int FIFO_DEPTH  = 4,
    parameter int COOLDOWN    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [7:0] random,
    output logic       act_valid,
    output logic [2:0] act_code,
    output logic       act_dir,
    input  logic       act_ready,
    output logic       second,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, COOL = 2'd2} state_t;

    // Map a received byte to {valid, stat code}.
    function automatic logic [3:0] decode_cmd(input logic [7:0] b);
        logic [3:0] r;
        case (b)
            8'h65:   r = 4'b1_000;
            8'h73:   r = 4'b1_001;
            8'h6D:   r = 4'b1_010;
            8'h62:   r = 4'b1_011;
            8'h7A:   r = 4'b1_100;
            8'h70:   r = 4'b1_101;
            default: r = 4'b0_000;
        endcase
        return r;
    endfunction

    state_t        state_r;
    logic [TW-1:0] tick_cnt_r;
    logic          second_r;
    logic          decay_pend_r;
    logic [2:0]    decay_code_r;
    logic [2:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r, count_nxt_s;
    logic          fifo_full_r;
    logic [7:0]    drop_cnt_r;
    logic          act_valid_r, act_dir_r, src_uart_r, resume_cool_r;
    logic [2:0]    act_code_r;
    logic [CW-1:0] cool_r;

    logic       tick_s, empty_s, full_s, pop_s, push_s, drop_s, dup_s, cmd_ok_s, take_pend_s;
    logic [3:0] dec_s;
    logic       unused_random_s;

    assign unused_random_s = ^random[7:3];
    assign tick_s      = (tick_cnt_r == TICK_LAST);
    assign dec_s       = decode_cmd(rx_data);
    assign cmd_ok_s    = rx_valid & dec_s[3];
    assign empty_s     = (count_r == '0);
    assign full_s      = (count_r == FULL_CNT);
    assign pop_s       = (state_r == IDLE) & ~decay_pend_r & ~empty_s;
    assign take_pend_s = decay_pend_r & ((state_r == IDLE) | (state_r == COOL));
    assign push_s      = cmd_ok_s & ~dup_s & (~full_s | pop_s);
    assign drop_s      = cmd_ok_s & ~dup_s & full_s & ~pop_s;

`ifdef CARE_DEDUP_EN
    logic [2:0] last_code_r;
    // The newest FIFO entry is still queued exactly while the FIFO is non-empty.
    assign dup_s = ~empty_s & (last_code_r == dec_s[2:0]);

    // Remember the code of the most recent push for auto-repeat suppression.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_code_r <= 3'd0;
        end else if (push_s) begin
            last_code_r <= dec_s[2:0];
        end else begin
            last_code_r <= last_code_r;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Next FIFO occupancy.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + (AW + 1)'(1);
            2'b01:   count_nxt_s = count_r - (AW + 1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Timebase, second toggle and the single pending decay slot (a new tick wins over a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r   <= '0;
            second_r     <= 1'b0;
            decay_pend_r <= 1'b0;
            decay_code_r <= 3'd0;
        end else begin
            if (tick_s) begin
                tick_cnt_r <= '0;
                second_r   <= ~second_r;
            end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
            end
            if (tick_s && (random[2:0] < 3'd6)) begin
                decay_pend_r <= 1'b1;
                decay_code_r <= random[2:0];
            end else if (take_pend_s) begin
                decay_pend_r <= 1'b0;
            end else begin
                decay_pend_r <= decay_pend_r;
            end
        end
    end

    // FIFO storage needs no reset; occupancy tracking makes stale entries invisible.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= dec_s[2:0];
        end
    end

    // FIFO pointers, occupancy, full flag and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            fifo_full_r <= 1'b0;
            drop_cnt_r  <= 8'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r     <= count_nxt_s;
            fifo_full_r <= (count_nxt_s == FULL_CNT);
            if (drop_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    // Issue FSM; a decay arriving during cooldown is served with the count frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            act_valid_r   <= 1'b0;
            act_code_r    <= 3'd0;
            act_dir_r     <= 1'b0;
            src_uart_r    <= 1'b0;
            resume_cool_r <= 1'b0;
            cool_r        <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (decay_pend_r) begin
                        act_valid_r   <= 1'b1;
                        act_code_r    <= decay_code_r;
                        act_dir_r     <= 1'b1;
                        src_uart_r    <= 1'b0;
                        resume_cool_r <= 1'b0;
                        state_r       <= ISSUE;
                    end else if (!empty_s) begin
                        act_valid_r <= 1'b1;
                        act_code_r  <= mem_r[rd_ptr_r];
                        act_dir_r   <= 1'b0;
                        src_uart_r  <= 1'b1;
                        state_r     <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (act_ready) begin
                        act_valid_r <= 1'b0;
                        if (src_uart_r) begin
                            cool_r  <= COOL_INIT;
                            state_r <= COOL;
                        end else if (resume_cool_r) begin
                            state_r <= COOL;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                COOL: begin
                    if (decay_pend_r) begin
                        act_valid_r   <= 1'b1;
                        act_code_r    <= decay_code_r;
                        act_dir_r     <= 1'b1;
                        src_uart_r    <= 1'b0;
                        resume_cool_r <= 1'b1;
                        state_r       <= ISSUE;
                    end else if (cool_r <= CW'(1)) begin
                        cool_r  <= '0;
                        state_r <= IDLE;
                    end else begin
                        cool_r <= cool_r - CW'(1);
                    end
                end
                default: begin
                    act_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign act_valid = act_valid_r;
    assign act_code  = act_code_r;
    assign act_dir   = act_dir_r;
    assign second    = second_r;
    assign fifo_full = fifo_full_r;
    assign drop_cnt  = drop_cnt_r;
endmodule

// File: tb/tb_care_scheduler.sv
// Scoreboard bench for care_scheduler: a queue-based reference model predicts actions and flags.
module tb_care_scheduler;
    localparam int TICK = 10;
    localparam int DEPTH = 4;
    localparam int COOL = 4;

    logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, act_ready = 1'b0;
    logic [7:0] rx_data = 8'h00, random = 8'h07;
    logic act_valid, act_dir, second, fifo_full;
    logic [2:0] act_code;
    logic [7:0] drop_cnt;

    care_scheduler #(.TICK_CYCLES(TICK), .FIFO_DEPTH(DEPTH), .COOLDOWN(COOL)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .random(random),
        .act_valid(act_valid), .act_code(act_code), .act_dir(act_dir), .act_ready(act_ready),
        .second(second), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0;

    // Reference model state: a command queue, one pending decay, one outstanding action, a cooldown budget.
    int m_tcnt, m_pcode, m_drops, m_cool, m_code, m_dec;
    bit m_sec, m_pend, m_out, m_dir, m_uart, m_took, m_dup;
    int m_q[$];
    int exp_q[$];
    logic [7:0] keys [6] = '{8'h65, 8'h73, 8'h6D, 8'h62, 8'h7A, 8'h70};

    function automatic int decode(input logic [7:0] b);
        for (int i = 0; i < 6; i++) if (keys[i] == b) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tcnt = 0; m_sec = 0; m_pend = 0; m_pcode = 0; m_drops = 0;
            m_cool = 0; m_out = 0; m_code = 0; m_dir = 0; m_uart = 0;
            m_q.delete(); exp_q.delete();
        end else begin
            m_dec = rx_valid ? decode(rx_data) : -1;
            m_dup = 0;
`ifdef CARE_DEDUP_EN
            if (m_dec >= 0 && m_q.size() > 0 && m_q[$] == m_dec) m_dup = 1;
`endif
            m_took = 0;
            if (m_out) begin
                if (act_ready) begin
                    m_out = 0;
                    if (m_uart) m_cool = COOL;
                end
            end else if (m_pend) begin
                m_out = 1; m_code = m_pcode; m_dir = 1; m_uart = 0; m_took = 1;
                exp_q.push_back(m_code * 2 + 1);
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (m_q.size() > 0) begin
                m_out = 1; m_code = m_q.pop_front(); m_dir = 0; m_uart = 1;
                exp_q.push_back(m_code * 2);
            end
            if (m_dec >= 0 && !m_dup) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_dec);
                else if (m_drops < 255) m_drops++;
            end
            if (m_took) m_pend = 0;
            if (m_tcnt == TICK - 1) begin
                m_tcnt = 0;
                m_sec = !m_sec;
                if (int'(random[2:0]) < 6) begin
                    m_pend = 1;
                    m_pcode = int'(random[2:0]);
                end
            end else begin
                m_tcnt++;
            end
        end
    end

    // Monitor: compare flags every cycle and pop the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!reset) begin
            chk("act_valid", int'(act_valid), int'(m_out));
            chk("second", int'(second), int'(m_sec));
            chk("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
            chk("drop_cnt", int'(drop_cnt), m_drops);
            if (act_valid && act_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_action", 1, 0);
                end else begin
                    chk("action", int'(act_code) * 2 + int'(act_dir), exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        cyc(1);
        rx_valid = 1'b0;
    endtask

    logic [7:0] pool [8] = '{8'h65, 8'h73, 8'h6D, 8'h62, 8'h7A, 8'h70, 8'h41, 8'h00};

    initial begin
        #2;
        chk("rst_act_valid", int'(act_valid), 0);
        chk("rst_act_code", int'(act_code), 0);
        chk("rst_act_dir", int'(act_dir), 0);
        chk("rst_second", int'(second), 0);
        chk("rst_fifo_full", int'(fifo_full), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        cyc(3);
        reset = 1'b0;
        // Single UART command and cooldown.
        act_ready = 1'b1;
        send(8'h65);
        cyc(12);
        // Decay ticks, then suppressed samples.
        random = 8'h03; cyc(35);
        random = 8'h07; cyc(25);
        // Stall, fill, overflow and ignored byte.
        act_ready = 1'b0;
        send(8'h73); send(8'h6D); send(8'h62); send(8'h7A); send(8'h70); send(8'h65); send(8'h41);
        cyc(5);
        act_ready = 1'b1; cyc(40);
        // Decay racing a queued command, and a tick during cooldown.
        act_ready = 1'b0; send(8'h73); send(8'h65); random = 8'h05; cyc(12);
        random = 8'h07; act_ready = 1'b1; cyc(30);
        send(8'h62); random = 8'h02; cyc(12); random = 8'h07; cyc(20);
        // Repeated key while the first copy is still queued.
        act_ready = 1'b0; send(8'h7A); send(8'h65); send(8'h65); cyc(3);
        act_ready = 1'b1; cyc(30);
        // Reset while an action is stalled in issue.
        act_ready = 1'b0; send(8'h70); cyc(2);
        reset = 1'b1; #1;
        chk("async_reset_act_valid", int'(act_valid), 0);
        cyc(2); reset = 1'b0;
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rx_valid  = ($urandom_range(0, 3) == 0);
            rx_data   = pool[$urandom_range(0, 7)];
            act_ready = ($urandom_range(0, 3) != 0);
            random    = 8'($urandom);
            cyc(1);
        end
        rx_valid = 1'b0; act_ready = 1'b1; random = 8'h07;
        cyc(80);
        chk("drain_scoreboard", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
